// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default geometry for the instruction cache.
package cache_pkg;
  localparam int DEF_TAG_W = 20;
  localparam int DEF_INDEX_W = 8;
  localparam int DEF_OFFSET_W = 4;
  localparam int LINE_WORDS = 2 ** (DEF_OFFSET_W - 2);
  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, REFILL} icache_state_e;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;
endpackage

// File: rtl/icache_way.sv
// icache_way: valid/tag/data storage for one cache way, single index shared by read and write.
module icache_way #(
  parameter int TAG_W = 20,
  parameter int INDEX_W = 8,
  parameter int LW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [INDEX_W-1:0]   index,
  input  logic                 we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LW-1:0][31:0]  wr_line,
  output logic                 valid,
  output logic [TAG_W-1:0]     tag,
  output logic [LW-1:0][31:0]  line
);
  localparam int SETS = 2 ** INDEX_W;
  logic [SETS-1:0] vbits;
  logic [TAG_W-1:0] tags [SETS];
  logic [LW-1:0][31:0] lines [SETS];
  always_ff @(posedge clk) begin
    if (rst || clr) vbits <= '0;
    else if (we) vbits[index] <= 1'b1;
  end
  // tag/data are RAM-like: no reset, qualified by the valid bit
  always_ff @(posedge clk) begin
    if (we) begin
      tags[index] <= wr_tag;
      lines[index] <= wr_line;
    end
  end
  assign valid = vbits[index];
  assign tag = tags[index];
  assign line = lines[index];
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: 2-way set-associative instruction cache with LRU replacement and 4-beat line refill.
module icache_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INDEX_W-1:0]  req_index,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic [OFFSET_W-1:0] req_offset,
  input  logic                flush,
  output logic                resp_valid,
  output logic [31:0]         resp_inst,
  output logic                rd_req,
  output logic [31:0]         rd_addr,
  input  logic                rd_ready,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data
);
  localparam int LW = 2 ** (OFFSET_W - 2);
  localparam int WW = OFFSET_W - 2;
  localparam int SETS = 2 ** INDEX_W;
  icache_state_e state;
  logic [TAG_W-1:0] tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [WW-1:0] word_q, cnt;
  logic [SETS-1:0] lru;
  logic victim, flush_pend;
  logic [LW-1:0][31:0] rbuf, fill;
  logic [1:0] v, hit, wr_en;
  logic [1:0][TAG_W-1:0] t;
  logic [1:0][LW-1:0][31:0] d;
  logic lookup_hit, do_flush, accept, refill_done, next_victim;
  assign hit = {v[1] && t[1] == tag_q, v[0] && t[0] == tag_q};
  assign lookup_hit = state == LOOKUP && |hit;
  assign do_flush = (flush || flush_pend) && (state == IDLE || lookup_hit);
  assign req_ready = !rst && !do_flush && (state == IDLE || lookup_hit);
  assign accept = req_valid && req_ready;
  assign refill_done = state == REFILL && ret_valid && ret_last;
  assign next_victim = !v[0] ? 1'b0 : !v[1] ? 1'b1 : lru[idx_q];
  always_comb begin
    fill = rbuf;
    fill[cnt] = ret_data;
  end
  for (genvar g = 0; g < 2; g++) begin : g_way
    assign wr_en[g] = refill_done && victim == 1'(g);
    icache_way #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .LW(LW)) u_way (
      .clk(clk), .rst(rst), .clr(do_flush), .index(idx_q), .we(wr_en[g]),
      .wr_tag(tag_q), .wr_line(fill), .valid(v[g]), .tag(t[g]), .line(d[g])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lru <= '0;
      resp_valid <= 1'b0;
      resp_inst <= '0;
      rd_req <= 1'b0;
      rd_addr <= '0;
      cnt <= '0;
      flush_pend <= 1'b0;
      victim <= 1'b0;
      tag_q <= '0;
      idx_q <= '0;
      word_q <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        tag_q <= req_tag;
        idx_q <= req_index;
        word_q <= req_offset[OFFSET_W-1:2];
      end
      // a flush that cannot be honoured now waits for the next IDLE
      flush_pend <= do_flush ? 1'b0 : flush_pend || flush;
      case (state)
        IDLE: if (accept) state <= LOOKUP;
        LOOKUP:
          if (|hit) begin
            resp_valid <= 1'b1;
            resp_inst <= hit[0] ? d[0][word_q] : d[1][word_q];
            lru[idx_q] <= hit[0];
            state <= accept ? LOOKUP : IDLE;
          end else begin
            victim <= next_victim;
            rd_req <= 1'b1;
            rd_addr <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
            state <= MISS;
          end
        MISS:
          if (rd_ready) begin
            rd_req <= 1'b0;
            cnt <= '0;
            state <= REFILL;
          end
        REFILL:
          if (ret_valid) begin
            rbuf[cnt] <= ret_data;
            cnt <= cnt + WW'(1);
            if (ret_last) begin
              resp_valid <= 1'b1;
              resp_inst <= fill[word_q];
              lru[idx_q] <= ~victim;
              state <= IDLE;
            end
          end
      endcase
      if (do_flush) lru <= '0;
    end
  end
  a_last_beat: assert property (@(posedge clk) disable iff (rst)
    !(state == REFILL && ret_valid && !ret_last && cnt == WW'(LW - 1)));
  a_aligned: assert property (@(posedge clk) disable iff (rst)
    accept |-> req_offset[1:0] == 2'b00);
  a_one_hit: assert property (@(posedge clk) disable iff (rst)
    state == LOOKUP |-> hit != 2'b11);
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed checks of hit/miss/refill, LRU replacement, flush, back-pressure and reset.
module tb_icache_ctrl;
  logic clk = 0, rst = 1, req_valid = 0, flush = 0, rd_ready = 0, ret_valid = 0, ret_last = 0;
  logic [7:0] req_index = 0;
  logic [19:0] req_tag = 0;
  logic [3:0] req_offset = 0;
  logic [31:0] ret_data = 0;
  logic req_ready, resp_valid, rd_req;
  logic [31:0] resp_inst, rd_addr;
  int total = 0, bad = 0, resp_cnt = 0, snap;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag), .req_offset(req_offset), .flush(flush),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (resp_valid) resp_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [19:0] tg, input logic [7:0] ix, input logic [3:0] of);
    req_valid = 1; req_tag = tg; req_index = ix; req_offset = of;
    #1 chk({tag, "_req_ready"}, {31'b0, req_ready}, 1);
    @(negedge clk); req_valid = 0;
  endtask

  task automatic wait_rd(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!rd_req && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rd_req"}, {31'b0, rd_req}, 1);
    chk({tag, "_rd_addr"}, rd_addr, addr);
  endtask

  task automatic refill(input string tag, input logic [31:0] b0, b1, b2, b3, exp);
    logic [3:0][31:0] b;
    b = {b3, b2, b1, b0};
    rd_ready = 1; @(negedge clk); rd_ready = 0;
    chk({tag, "_rd_req_drop"}, {31'b0, rd_req}, 0);
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1; ret_data = b[i]; ret_last = (i == 3);
      @(negedge clk);
    end
    ret_valid = 0; ret_last = 0;
    #1 chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 1);
    chk({tag, "_resp_inst"}, resp_inst, exp);
  endtask

  task automatic miss(input string tag, input logic [19:0] tg, input logic [7:0] ix, input logic [3:0] of,
                      input logic [31:0] b0, b1, b2, b3, exp);
    issue(tag, tg, ix, of);
    wait_rd(tag, {tg, ix, 4'h0});
    refill(tag, b0, b1, b2, b3, exp);
  endtask

  task automatic hit(input string tag, input logic [19:0] tg, input logic [7:0] ix, input logic [3:0] of,
                     input logic [31:0] exp);
    issue(tag, tg, ix, of);
    #1 chk({tag, "_no_rd_req"}, {31'b0, rd_req}, 0);
    @(negedge clk);
    #1 chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 1);
    chk({tag, "_resp_inst"}, resp_inst, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    #1 chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_inst", resp_inst, 0);
    chk("rst_rd_req", {31'b0, rd_req}, 0);
    chk("rst_rd_addr", rd_addr, 0);
    rst = 0;
    @(negedge clk);
    // cold miss
    miss("cold", 20'h1C000, 8'h00, 4'h4, 32'h11, 32'h22, 32'h33, 32'h44, 32'h22);
    // hit streaming, one fetch per cycle
    req_valid = 1; req_tag = 20'h1C000; req_index = 0; req_offset = 4'h0;
    #1 chk("s0_ready", {31'b0, req_ready}, 1);
    @(negedge clk); req_offset = 4'h8;
    #1 chk("s1_ready", {31'b0, req_ready}, 1);
    @(negedge clk); req_offset = 4'hC;
    #1 chk("s2_ready", {31'b0, req_ready}, 1);
    chk("s0_valid", {31'b0, resp_valid}, 1);
    chk("s0_inst", resp_inst, 32'h11);
    @(negedge clk); req_valid = 0;
    #1 chk("s1_valid", {31'b0, resp_valid}, 1);
    chk("s1_inst", resp_inst, 32'h33);
    @(negedge clk);
    #1 chk("s2_valid", {31'b0, resp_valid}, 1);
    chk("s2_inst", resp_inst, 32'h44);
    chk("s_no_rd_req", {31'b0, rd_req}, 0);
    @(negedge clk);
    #1 chk("s_end_valid", {31'b0, resp_valid}, 0);
    // LRU replacement in set 5
    miss("fillA", 20'h0000A, 8'h05, 4'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0);
    miss("fillB", 20'h0000B, 8'h05, 4'h4, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB1);
    hit("touchA", 20'h0000A, 8'h05, 4'h8, 32'hA2);
    miss("fillC", 20'h0000C, 8'h05, 4'hC, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC3);
    hit("keepA", 20'h0000A, 8'h05, 4'h0, 32'hA0);
    miss("reB", 20'h0000B, 8'h05, 4'h0, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE0);
    hit("stillA", 20'h0000A, 8'h05, 4'h4, 32'hA1);
    // flush in IDLE blocks a same-cycle request and invalidates everything
    @(negedge clk);
    snap = resp_cnt;
    flush = 1; req_valid = 1; req_tag = 20'h0000A; req_index = 8'h05; req_offset = 4'h0;
    #1 chk("flush_ready", {31'b0, req_ready}, 0);
    @(negedge clk); flush = 0; req_valid = 0;
    @(negedge clk);
    #1 chk("flush_no_resp", resp_cnt, snap);
    miss("postflush", 20'h0000A, 8'h05, 4'h4, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD1);
    // back-pressure on the read request
    issue("bp", 20'h12345, 8'h33, 4'h8);
    wait_rd("bp", 32'h12345330);
    snap = resp_cnt;
    req_valid = 1; req_tag = 20'h00001; req_index = 8'h01; req_offset = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("bp_rd_req", {31'b0, rd_req}, 1);
      chk("bp_rd_addr", rd_addr, 32'h12345330);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
    end
    chk("bp_no_resp", resp_cnt, snap);
    req_valid = 0;
    refill("bp", 32'h51, 32'h52, 32'h53, 32'h54, 32'h53);
    // reset in the middle of a refill
    issue("mid", 20'h00777, 8'h10, 4'hC);
    wait_rd("mid", 32'h00777100);
    rd_ready = 1; @(negedge clk); rd_ready = 0;
    ret_valid = 1; ret_data = 32'h71; @(negedge clk);
    ret_data = 32'h72; @(negedge clk);
    snap = resp_cnt;
    ret_valid = 0; rst = 1;
    #1 chk("mid_rst_ready", {31'b0, req_ready}, 0);
    @(negedge clk); rst = 0;
    #1 chk("mid_rd_req", {31'b0, rd_req}, 0);
    chk("mid_resp_valid", {31'b0, resp_valid}, 0);
    @(negedge clk);
    #1 chk("mid_no_resp", resp_cnt, snap);
    miss("again", 20'h00777, 8'h10, 4'hC, 32'h81, 32'h82, 32'h83, 32'h84, 32'h84);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
